// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a valid host start pulse with the response preamble and a 40-bit frame.
// Optional macro DHT11_RESP_CHKSUM_ERR_EN adds corrupt_checksum to flip the checksum LSB for host error tests.
module dht11_responder #(
    parameter int START_LOW_MIN_US = 18000,
    parameter int RESP_DELAY_US    = 30,
    parameter int RESP_LOW_US      = 80,
    parameter int RESP_HIGH_US     = 80,
    parameter int BIT_LOW_US       = 50,
    parameter int BIT0_HIGH_US     = 27,
    parameter int BIT1_HIGH_US     = 70,
    parameter int CNT_W            = 16
) (
    input  logic       clk_1mhz,
    input  logic       reset,
    inout  wire        sensor_pin,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_CHKSUM_ERR_EN
    input  logic       corrupt_checksum,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] checksum
);

    typedef enum logic [3:0] {
        IDLE, HOST_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, END_LOW, REARM
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic [39:0]        frame_q;
    logic [7:0]         checksum_q;
    logic [1:0]         sync_q;
    logic               drv_q;
    logic               fd_pend_q;
    logic               frame_done_q;
    logic               pin_s;
    logic               latch;
    logic               end_pulse;
    logic               phase_last;
    logic [CNT_W-1:0]   phase_len;
    logic [7:0]         chk_c;

    assign pin_s      = sync_q[1];
    assign sensor_pin = drv_q ? 1'b0 : 1'bz;
    assign busy       = (state_q == RESP_DELAY) || (state_q == RESP_LOW) ||
                        (state_q == RESP_HIGH)  || (state_q == BIT_LOW)  ||
                        (state_q == BIT_HIGH)   || (state_q == END_LOW);
    assign frame_done = frame_done_q;
    assign checksum   = checksum_q;

    always_comb begin
        chk_c = hum_int + hum_dec + temp_int + temp_dec;
`ifdef DHT11_RESP_CHKSUM_ERR_EN
        chk_c[0] = chk_c[0] ^ corrupt_checksum;
`endif
    end

    // Bit currently on the wire is always frame_q[39]; the frame shifts left after each bit.
    always_comb begin
        phase_len = '1;
        case (state_q)
            RESP_DELAY: phase_len = CNT_W'(RESP_DELAY_US);
            RESP_LOW:   phase_len = CNT_W'(RESP_LOW_US);
            RESP_HIGH:  phase_len = CNT_W'(RESP_HIGH_US);
            BIT_LOW:    phase_len = CNT_W'(BIT_LOW_US);
            BIT_HIGH:   phase_len = frame_q[39] ? CNT_W'(BIT1_HIGH_US) : CNT_W'(BIT0_HIGH_US);
            END_LOW:    phase_len = CNT_W'(BIT_LOW_US);
            default:    ;
        endcase
    end

    assign phase_last = (cnt_q == phase_len - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        latch     = 1'b0;
        end_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (!pin_s) begin
                    state_d = HOST_LOW;
                    cnt_d   = '0;
                end
            end
            HOST_LOW: begin
                if (pin_s) begin
                    cnt_d = '0;
                    if (cnt_q >= CNT_W'(START_LOW_MIN_US)) begin
                        state_d = RESP_DELAY;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q < CNT_W'(START_LOW_MIN_US)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW: begin
                cnt_d = phase_last ? '0 : cnt_q + CNT_W'(1);
                if (phase_last) begin
                    case (state_q)
                        RESP_DELAY: state_d = RESP_LOW;
                        RESP_LOW:   state_d = RESP_HIGH;
                        RESP_HIGH: begin
                            state_d = BIT_LOW;
                            idx_d   = '0;
                        end
                        BIT_LOW:    state_d = BIT_HIGH;
                        BIT_HIGH: begin
                            if (idx_q == 6'd39) begin
                                state_d = END_LOW;
                            end else begin
                                state_d = BIT_LOW;
                                idx_d   = idx_q + 6'd1;
                            end
                        end
                        default: begin
                            state_d   = REARM;
                            end_pulse = 1'b1;
                        end
                    endcase
                end
            end
            REARM: begin
                // Our own end pulse is still visible through the synchronizer for a few cycles.
                if (pin_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1mhz) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            checksum_q   <= '0;
            sync_q       <= 2'b11;
            drv_q        <= 1'b0;
            fd_pend_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sync_q  <= {sync_q[0], sensor_pin};
            drv_q   <= (state_q == RESP_LOW) || (state_q == BIT_LOW) || (state_q == END_LOW);
            if (latch) begin
                frame_q    <= {hum_int, hum_dec, temp_int, temp_dec, chk_c};
                checksum_q <= chk_c;
            end else if (state_q == BIT_HIGH && phase_last) begin
                frame_q <= {frame_q[38:0], 1'b0};
            end
            // Delay the pulse one cycle so it lines up with the release after the end pulse.
            fd_pend_q    <= end_pulse;
            frame_done_q <= fd_pend_q;
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: acts as the host, decodes the bus and checks frames and flags.
`timescale 1ns/1ps
module tb_dht11_responder;

    logic       clk_1mhz = 1'b0;
    logic       reset    = 1'b0;
    logic       host_drv = 1'b0;
    logic [7:0] hum_int  = 8'h00;
    logic [7:0] hum_dec  = 8'h00;
    logic [7:0] temp_int = 8'h00;
    logic [7:0] temp_dec = 8'h00;
    logic       busy;
    logic       frame_done;
    logic [7:0] checksum;
    wire        sensor_pin;
`ifdef DHT11_RESP_CHKSUM_ERR_EN
    logic       corrupt_checksum = 1'b0;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int fd_cnt     = 0;

    assign sensor_pin = host_drv ? 1'b0 : 1'bz;
    pullup (sensor_pin);

    always #500 clk_1mhz = ~clk_1mhz;

    always @(negedge clk_1mhz) if (frame_done === 1'b1) fd_cnt++;

    dht11_responder #(.START_LOW_MIN_US(100)) dut (
        .clk_1mhz   (clk_1mhz),
        .reset      (reset),
        .sensor_pin (sensor_pin),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
`ifdef DHT11_RESP_CHKSUM_ERR_EN
        .corrupt_checksum (corrupt_checksum),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .checksum   (checksum)
    );

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
    endtask

    task automatic host_start(input int low_us);
        repeat (20) @(negedge clk_1mhz);
        host_drv = 1'b1;
        repeat (low_us) @(negedge clk_1mhz);
        host_drv = 1'b0;
    endtask

    // Length of the run of samples at level lvl, bounded so a stuck bus cannot hang the bench.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (sensor_pin === lvl && n < 300) begin
            n++;
            @(negedge clk_1mhz);
        end
    endtask

    task automatic rx_frame(input int chg_bit, input logic [7:0] chg_val,
                            output int dly, output int rlow, output int rhigh,
                            output logic [39:0] data, output int bad, output logic busy_mid);
        int n;
        bad  = 0;
        data = '0;
        @(negedge clk_1mhz);
        run_len(1'b1, n);
        dly = n + 1;
        busy_mid = busy;
        run_len(1'b0, rlow);
        run_len(1'b1, rhigh);
        for (int b = 0; b < 40; b++) begin
            run_len(1'b0, n);
            if (n != 50) bad++;
            if (b == chg_bit) temp_int = chg_val;
            run_len(1'b1, n);
            if (n == 70) begin
                data = {data[38:0], 1'b1};
            end else begin
                data = {data[38:0], 1'b0};
                if (n != 27) bad++;
            end
        end
        run_len(1'b0, n);
        if (n != 50) bad++;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (sensor_pin !== 1'b1) begin miscompares++; $display("FAIL reset_pin got=%b want=1", sensor_pin); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        vectors++;
        if (checksum !== 8'h00) begin miscompares++; $display("FAIL reset_checksum got=%h want=00", checksum); end
        $display("test_reset: pin=%b busy=%b fd=%b chk=%h", sensor_pin, busy, frame_done, checksum);
    endtask

    task automatic test_frame();
        int dly, rl, rh, bad, fd0;
        logic [39:0] d;
        logic bm;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        fd0 = fd_cnt;
        host_start(120);
        rx_frame(-1, 8'h00, dly, rl, rh, d, bad, bm);
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (dly < 30 || dly > 36) begin miscompares++; $display("FAIL frame_resp_delay got=%0d want=30..36", dly); end
        vectors++;
        if (rl != 80) begin miscompares++; $display("FAIL frame_resp_low got=%0d want=80", rl); end
        vectors++;
        if (rh != 80) begin miscompares++; $display("FAIL frame_resp_high got=%0d want=80", rh); end
        vectors++;
        if (d !== 40'h3700190555) begin miscompares++; $display("FAIL frame_data got=%h want=3700190555", d); end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL frame_bit_timing got=%0d bad phases want=0", bad); end
        vectors++;
        if (bm !== 1'b1) begin miscompares++; $display("FAIL frame_busy_mid got=%b want=1", bm); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_after got=%b want=0", busy); end
        vectors++;
        if (checksum !== 8'h55) begin miscompares++; $display("FAIL frame_checksum got=%h want=55", checksum); end
        vectors++;
        if (fd_cnt - fd0 != 1) begin miscompares++; $display("FAIL frame_done_pulses got=%0d want=1", fd_cnt - fd0); end
        $display("test_frame: dly=%0d low=%0d high=%0d data=%h chk=%h", dly, rl, rh, d, checksum);
    endtask

    task automatic test_short_start();
        int drv_seen, busy_seen, fd0;
        drv_seen = 0; busy_seen = 0; fd0 = fd_cnt;
        host_start(60);
        repeat (300) begin
            @(negedge clk_1mhz);
            if (sensor_pin === 1'b0) drv_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        vectors++;
        if (drv_seen != 0) begin miscompares++; $display("FAIL short_pin_driven got=%0d cycles want=0", drv_seen); end
        vectors++;
        if (busy_seen != 0) begin miscompares++; $display("FAIL short_busy got=%0d cycles want=0", busy_seen); end
        vectors++;
        if (fd_cnt != fd0) begin miscompares++; $display("FAIL short_frame_done got=%0d want=%0d", fd_cnt, fd0); end
        $display("test_short_start: driven=%0d busy=%0d", drv_seen, busy_seen);
    endtask

    task automatic test_wrap();
        int dly, rl, rh, bad;
        logic [39:0] d;
        logic bm;
        set_bytes(8'hFF, 8'hFF, 8'h02, 8'h01);
        host_start(120);
        rx_frame(-1, 8'h00, dly, rl, rh, d, bad, bm);
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (d !== 40'hFFFF020101) begin miscompares++; $display("FAIL wrap_data got=%h want=ffff020101", d); end
        vectors++;
        if (checksum !== 8'h01) begin miscompares++; $display("FAIL wrap_checksum got=%h want=01", checksum); end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL wrap_bit_timing got=%0d want=0", bad); end
        $display("test_wrap: data=%h chk=%h", d, checksum);
    endtask

    task automatic test_reset_mid();
        int n, fd0, dly, rl, rh, bad;
        logic [39:0] d;
        logic bm;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(120);
        @(negedge clk_1mhz);
        run_len(1'b1, n);
        run_len(1'b0, n);
        run_len(1'b1, n);
        for (int b = 0; b < 20; b++) begin
            run_len(1'b0, n);
            run_len(1'b1, n);
        end
        repeat (10) @(negedge clk_1mhz);
        fd0 = fd_cnt;
        reset = 1'b0;
        @(negedge clk_1mhz);
        vectors++;
        if (sensor_pin !== 1'b1) begin miscompares++; $display("FAIL midreset_pin got=%b want=1", sensor_pin); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk_1mhz);
        reset = 1'b1;
        repeat (150) @(negedge clk_1mhz);
        vectors++;
        if (fd_cnt != fd0) begin miscompares++; $display("FAIL midreset_frame_done got=%0d want=%0d", fd_cnt, fd0); end
        host_start(120);
        rx_frame(-1, 8'h00, dly, rl, rh, d, bad, bm);
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (d !== 40'h3700190555) begin miscompares++; $display("FAIL midreset_refresh_data got=%h want=3700190555", d); end
        vectors++;
        if (checksum !== 8'h55) begin miscompares++; $display("FAIL midreset_checksum got=%h want=55", checksum); end
        vectors++;
        if (fd_cnt - fd0 != 1) begin miscompares++; $display("FAIL midreset_done_after got=%0d want=1", fd_cnt - fd0); end
        $display("test_reset_mid: data=%h chk=%h", d, checksum);
    endtask

    task automatic test_snapshot();
        int dly, rl, rh, bad;
        logic [39:0] d;
        logic bm;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(120);
        rx_frame(5, 8'h20, dly, rl, rh, d, bad, bm);
        vectors++;
        if (d !== 40'h3700190555) begin miscompares++; $display("FAIL snapshot_cur got=%h want=3700190555", d); end
        host_start(120);
        rx_frame(-1, 8'h00, dly, rl, rh, d, bad, bm);
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (d !== 40'h370020055C) begin miscompares++; $display("FAIL snapshot_next got=%h want=370020055c", d); end
        vectors++;
        if (checksum !== 8'h5C) begin miscompares++; $display("FAIL snapshot_checksum got=%h want=5c", checksum); end
        $display("test_snapshot: next=%h chk=%h", d, checksum);
    endtask

`ifdef DHT11_RESP_CHKSUM_ERR_EN
    task automatic test_corrupt();
        int dly, rl, rh, bad;
        logic [39:0] d;
        logic bm;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        corrupt_checksum = 1'b1;
        host_start(120);
        rx_frame(-1, 8'h00, dly, rl, rh, d, bad, bm);
        corrupt_checksum = 1'b0;
        repeat (5) @(negedge clk_1mhz);
        vectors++;
        if (d !== 40'h3700190554) begin miscompares++; $display("FAIL corrupt_data got=%h want=3700190554", d); end
        vectors++;
        if (checksum !== 8'h54) begin miscompares++; $display("FAIL corrupt_checksum got=%h want=54", checksum); end
        $display("test_corrupt: data=%h chk=%h", d, checksum);
    endtask
`endif

    initial begin
        test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk_1mhz);
        test_frame();
        test_short_start();
        test_wrap();
        test_reset_mid();
        test_snapshot();
`ifdef DHT11_RESP_CHKSUM_ERR_EN
        test_corrupt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #90_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
